// File: rtl/tictac_pkg.sv
// Shared definitions for the N x N, K-in-a-row board controller.
// Holds the controller state encoding, the scan direction encoding,
// the 12-bit colour palette and helpers that size board-related fields.
package tictac_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE,
    ST_CHECK,
    ST_WIN,
    ST_DRAW
  } state_t;

  // Order matters: the CHECK counter walks these in sequence.
  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D,
    DIR_A
  } dir_t;

  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] BLUE  = 12'h00F;
  localparam logic [11:0] GREEN = 12'h0F0;
  localparam logic [11:0] RICE  = 12'hEEC;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BLACK = 12'h000;

  // Width of a row or column coordinate.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the filled-cell counter (0..n*n inclusive).
  function automatic int moves_w(input int n);
    return $clog2(n * n + 1);
  endfunction

  // Width of a run length (0..n inclusive).
  function automatic int run_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tictac_line_scan.sv
// Combinational run-length measurement through one cell of one board.
// Ports:
//   board : N*N occupancy bits of a single player, index row*N+col
//   row   : row of the cell the run passes through
//   col   : column of the cell the run passes through
//   dir   : line orientation (horizontal, vertical, diagonal, anti-diagonal)
//   run   : 1 + contiguous owned cells on both sides, saturating at K
module tictac_line_scan
  import tictac_pkg::*;
#(
  parameter  int N  = 3,
  parameter  int K  = 3,
  localparam int CW = coord_w(N),
  localparam int RW = run_w(N)
) (
  input  logic [N*N-1:0] board,
  input  logic [CW-1:0]  row,
  input  logic [CW-1:0]  col,
  input  dir_t           dir,
  output logic [RW-1:0]  run
);

  localparam int BW = N * N;

  int          step_r;
  int          step_c;
  int          cell_r;
  int          cell_c;
  int          cell_idx;
  logic        still_run;
  logic [RW-1:0] count;

  // Walk outward on both sides of the cell; a side stops at the first empty
  // cell or at the board edge, so lines never wrap onto the next row.
  always_comb begin
    step_r    = 0;
    step_c    = 1;
    cell_r    = 0;
    cell_c    = 0;
    cell_idx  = 0;
    still_run = 1'b0;
    count     = RW'(1);
    case (dir)
      DIR_H:   begin step_r = 0; step_c = 1;  end
      DIR_V:   begin step_r = 1; step_c = 0;  end
      DIR_D:   begin step_r = 1; step_c = 1;  end
      default: begin step_r = 1; step_c = -1; end
    endcase
    for (int side = -1; side <= 1; side += 2) begin
      still_run = 1'b1;
      for (int i = 1; i < N; i++) begin
        cell_r = int'(row) + side * i * step_r;
        cell_c = int'(col) + side * i * step_c;
        if (cell_r < 0 || cell_r >= N || cell_c < 0 || cell_c >= N) begin
          still_run = 1'b0;
        end else begin
          cell_idx = cell_r * N + cell_c;
          if (!(|(board & (BW'(1) << cell_idx)))) begin
            still_run = 1'b0;
          end
        end
        if (still_run && (count < RW'(K))) begin
          count = count + 1'b1;
        end
      end
    end
    run = count;
  end

endmodule

// File: rtl/tictac_board_ctrl.sv
// Two-player N x N board controller with K-in-a-row win detection and
// per-pixel board rendering for the VGA path.
// Ports:
//   clk, rst                    : game clock, asynchronous active-high reset
//   up/down/left/right/place    : debounced button levels
//   bright, hCount, vCount      : active-video flag and pixel coordinates
//   rgb                         : registered pixel colour (1 cycle latency)
//   turn                        : 0 = player 1 to move, 1 = player 2
//   winner                      : 00 none, 01 P1, 10 P2, 11 draw
//   moves                       : number of filled cells
//   illegal                     : one-cycle pulse on place over an occupied cell
//   q_Init..q_Draw              : one-hot view of the controller state
module tictac_board_ctrl
  import tictac_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int K     = 3,
  parameter  int CELL  = 100,
  parameter  int GAP   = 5,
  parameter  int ORG_X = 308,
  parameter  int ORG_Y = 120,
  localparam int MW    = moves_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          place,
  input  logic          bright,
  input  logic [9:0]    hCount,
  input  logic [9:0]    vCount,
  output logic [11:0]   rgb,
  output logic          turn,
  output logic [1:0]    winner,
  output logic [MW-1:0] moves,
  output logic          illegal,
  output logic          q_Init,
  output logic          q_WaitPress,
  output logic          q_WaitRelease,
  output logic          q_Check,
  output logic          q_Win,
  output logic          q_Draw
);

  localparam int CW    = coord_w(N);
  localparam int RW    = run_w(N);
  localparam int BW    = N * N;
  localparam int PITCH = CELL + GAP;
  localparam int RAD   = CELL / 2;

  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [CW-1:0] CENTRE = CW'(N / 2);
  localparam logic [MW-1:0] FULL   = MW'(N * N);

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [BW-1:0] p1_q, p1_d;
  logic [BW-1:0] p2_q, p2_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] last_row_q, last_row_d;
  logic [CW-1:0] last_col_q, last_col_d;
  logic          turn_q, turn_d;
  logic [1:0]    winner_q, winner_d;
  logic [MW-1:0] moves_q, moves_d;
  logic          illegal_q, illegal_d;
  logic [11:0]   rgb_q, rgb_d;

  logic [BW-1:0] cur_bit;
  logic          occupied;
  logic          any_btn;
  logic [BW-1:0] scan_board;
  logic [RW-1:0] scan_run;

  // The scan only ever looks at the mover's board: the turn is not toggled
  // until the scan has finished without a win.
  assign scan_board = turn_q ? p2_q : p1_q;

  tictac_line_scan #(
    .N(N),
    .K(K)
  ) u_scan (
    .board(scan_board),
    .row  (last_row_q),
    .col  (last_col_q),
    .dir  (dir_q),
    .run  (scan_run)
  );

  // Game flow: navigation and placement in WAIT_PRESS, one direction per
  // cycle in CHECK, and a frozen board in WIN/DRAW until place starts over.
  // INIT always exits through WAIT_RELEASE so a button still held from the
  // previous game or from reset cannot act.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    row_d      = row_q;
    col_d      = col_q;
    last_row_d = last_row_q;
    last_col_d = last_col_q;
    turn_d     = turn_q;
    winner_d   = winner_q;
    moves_d    = moves_q;
    illegal_d  = 1'b0;
    cur_bit    = BW'(1) << (int'(row_q) * N + int'(col_q));
    occupied   = |((p1_q | p2_q) & cur_bit);
    any_btn    = up | down | left | right | place;

    case (state_q)
      ST_INIT: begin
        p1_d     = '0;
        p2_d     = '0;
        moves_d  = '0;
        turn_d   = 1'b0;
        row_d    = CENTRE;
        col_d    = CENTRE;
        winner_d = 2'b00;
        dir_d    = DIR_H;
        state_d  = ST_WAIT_RELEASE;
      end
      ST_WAIT_PRESS: begin
        if (place) begin
          if (occupied) begin
            illegal_d = 1'b1;
            state_d   = ST_WAIT_RELEASE;
          end else begin
            if (turn_q) p2_d = p2_q | cur_bit;
            else        p1_d = p1_q | cur_bit;
            moves_d    = moves_q + 1'b1;
            last_row_d = row_q;
            last_col_d = col_q;
            dir_d      = DIR_H;
            state_d    = ST_CHECK;
          end
        end else if (right) begin
          col_d   = (col_q == LAST) ? '0 : col_q + 1'b1;
          state_d = ST_WAIT_RELEASE;
        end else if (left) begin
          col_d   = (col_q == '0) ? LAST : col_q - 1'b1;
          state_d = ST_WAIT_RELEASE;
        end else if (up) begin
          row_d   = (row_q == '0) ? LAST : row_q - 1'b1;
          state_d = ST_WAIT_RELEASE;
        end else if (down) begin
          row_d   = (row_q == LAST) ? '0 : row_q + 1'b1;
          state_d = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!any_btn) state_d = ST_WAIT_PRESS;
      end
      ST_CHECK: begin
        if (scan_run >= RW'(K)) begin
          winner_d = turn_q ? 2'b10 : 2'b01;
          state_d  = ST_WIN;
        end else if (dir_q == DIR_A) begin
          if (moves_q == FULL) begin
            winner_d = 2'b11;
            state_d  = ST_DRAW;
          end else begin
            turn_d  = ~turn_q;
            state_d = ST_WAIT_RELEASE;
          end
        end else begin
          dir_d = dir_t'(dir_q + 2'd1);
        end
      end
      ST_WIN, ST_DRAW: begin
        if (place) state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  int            px, py;
  int            lx, ly;
  int            hit_r, hit_c;
  logic          in_x, in_y;
  logic [BW-1:0] pix_bit;
  logic          on_cursor;

  // Pixel classification: find which cell column/row the pixel falls in
  // (gaps leave in_x/in_y low), then colour by cursor disc, owner or gap.
  always_comb begin
    px        = int'(hCount) - ORG_X;
    py        = int'(vCount) - ORG_Y;
    lx        = 0;
    ly        = 0;
    hit_r     = 0;
    hit_c     = 0;
    in_x      = 1'b0;
    in_y      = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (px >= c * PITCH && px < c * PITCH + CELL) begin
        in_x  = 1'b1;
        hit_c = c;
        lx    = px - c * PITCH - RAD;
      end
    end
    for (int r = 0; r < N; r++) begin
      if (py >= r * PITCH && py < r * PITCH + CELL) begin
        in_y  = 1'b1;
        hit_r = r;
        ly    = py - r * PITCH - RAD;
      end
    end
    pix_bit   = BW'(1) << (hit_r * N + hit_c);
    on_cursor = in_x && in_y && (hit_r == int'(row_q)) && (hit_c == int'(col_q)) &&
                (lx * lx + ly * ly < RAD * RAD);
    if (!bright)                    rgb_d = BLACK;
    else if (on_cursor)             rgb_d = GREEN;
    else if (!(in_x && in_y))       rgb_d = WHITE;
    else if (|(p1_q & pix_bit))     rgb_d = RED;
    else if (|(p2_q & pix_bit))     rgb_d = BLUE;
    else                            rgb_d = RICE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      dir_q      <= DIR_H;
      p1_q       <= '0;
      p2_q       <= '0;
      row_q      <= CENTRE;
      col_q      <= CENTRE;
      last_row_q <= CENTRE;
      last_col_q <= CENTRE;
      turn_q     <= 1'b0;
      winner_q   <= 2'b00;
      moves_q    <= '0;
      illegal_q  <= 1'b0;
      rgb_q      <= BLACK;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      row_q      <= row_d;
      col_q      <= col_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      turn_q     <= turn_d;
      winner_q   <= winner_d;
      moves_q    <= moves_d;
      illegal_q  <= illegal_d;
      rgb_q      <= rgb_d;
    end
  end

  assign rgb           = rgb_q;
  assign turn          = turn_q;
  assign winner        = winner_q;
  assign moves         = moves_q;
  assign illegal       = illegal_q;
  assign q_Init        = (state_q == ST_INIT);
  assign q_WaitPress   = (state_q == ST_WAIT_PRESS);
  assign q_WaitRelease = (state_q == ST_WAIT_RELEASE);
  assign q_Check       = (state_q == ST_CHECK);
  assign q_Win         = (state_q == ST_WIN);
  assign q_Draw        = (state_q == ST_DRAW);

endmodule

// File: tb/tb_tictac_board_ctrl.sv
// Bench for tictac_board_ctrl: a 3x3/K=3 instance and a 5x5/K=4 instance,
// driven by directed games and random button masks, checked against a
// board model that searches the whole board for K-long lines.
module tb_tictac_board_ctrl;

  localparam logic [11:0] C_RED   = 12'hF00;
  localparam logic [11:0] C_BLUE  = 12'h00F;
  localparam logic [11:0] C_GREEN = 12'h0F0;
  localparam logic [11:0] C_RICE  = 12'hEEC;
  localparam logic [11:0] C_WHITE = 12'hFFF;

  // Button vectors are {place, right, left, up, down}.
  localparam logic [4:0] B_PLACE = 5'b10000;
  localparam logic [4:0] B_RIGHT = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00001;
  localparam logic [4:0] B_UP    = 5'b00010;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] b3, b5;
  logic bright;
  logic [9:0] hCount, vCount;

  logic [11:0] rgb3, rgb5;
  logic turn3, turn5, ill3, ill5;
  logic [1:0] win3, win5;
  logic [3:0] mv3;
  logic [4:0] mv5;
  logic qi3, qwp3, qwr3, qc3, qw3, qd3;
  logic qi5, qwp5, qwr5, qc5, qw5, qd5;

  always #5 clk = ~clk;

  tictac_board_ctrl #(.N(3), .K(3)) dut3 (
    .clk(clk), .rst(rst),
    .up(b3[1]), .down(b3[0]), .left(b3[2]), .right(b3[3]), .place(b3[4]),
    .bright(bright), .hCount(hCount), .vCount(vCount),
    .rgb(rgb3), .turn(turn3), .winner(win3), .moves(mv3), .illegal(ill3),
    .q_Init(qi3), .q_WaitPress(qwp3), .q_WaitRelease(qwr3),
    .q_Check(qc3), .q_Win(qw3), .q_Draw(qd3)
  );

  tictac_board_ctrl #(.N(5), .K(4)) dut5 (
    .clk(clk), .rst(rst),
    .up(b5[1]), .down(b5[0]), .left(b5[2]), .right(b5[3]), .place(b5[4]),
    .bright(bright), .hCount(hCount), .vCount(vCount),
    .rgb(rgb5), .turn(turn5), .winner(win5), .moves(mv5), .illegal(ill5),
    .q_Init(qi5), .q_WaitPress(qwp5), .q_WaitRelease(qwr5),
    .q_Check(qc5), .q_Win(qw5), .q_Draw(qd5)
  );

  int sel;
  int total = 0;
  int bad = 0;

  logic [11:0] o_rgb;
  logic o_turn, o_ill, st_init, st_wp, st_wr, st_chk, st_win, st_draw;
  logic [1:0] o_winner;
  int o_moves;

  // Observation mux: the active instance is chosen by sel.
  always_comb begin
    if (sel == 1) begin
      o_rgb = rgb5; o_turn = turn5; o_ill = ill5; o_winner = win5; o_moves = int'(mv5);
      st_init = qi5; st_wp = qwp5; st_wr = qwr5; st_chk = qc5; st_win = qw5; st_draw = qd5;
    end else begin
      o_rgb = rgb3; o_turn = turn3; o_ill = ill3; o_winner = win3; o_moves = int'(mv3);
      st_init = qi3; st_wp = qwp3; st_wr = qwr3; st_chk = qc3; st_win = qw3; st_draw = qd3;
    end
  end

  // Reference model: cell owners (0 empty, 1 P1, 2 P2), cursor, turn, result.
  int mb[8][8];
  int mn, mk, mr, mc, mturn, mwin, mmoves;

  function automatic void model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mb[r][c] = 0;
    mr = mn / 2; mc = mn / 2; mturn = 0; mwin = 0; mmoves = 0;
  endfunction

  // True when player p owns any K consecutive cells anywhere on the board.
  function automatic bit has_line(input int p);
    int drs[4] = '{0, 1, 1, 1};
    int dcs[4] = '{1, 0, 1, -1};
    bit ok;
    int rr, cc;
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++)
        for (int d = 0; d < 4; d++) begin
          ok = 1'b1;
          for (int i = 0; i < mk; i++) begin
            rr = r + i * drs[d];
            cc = c + i * dcs[d];
            if (rr < 0 || rr >= mn || cc < 0 || cc >= mn) ok = 1'b0;
            else if (mb[rr][cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [11:0] owner_colour(input int r, input int c);
    if (mb[r][c] == 1) return C_RED;
    if (mb[r][c] == 2) return C_BLUE;
    return C_RICE;
  endfunction

  task automatic set_btn(input logic [4:0] v);
    if (sel == 1) b5 = v; else b3 = v;
  endtask

  task automatic hard_reset(input int which);
    @(negedge clk);
    b3 = '0; b5 = '0; rst = 1'b1; sel = which;
    @(negedge clk);
    rst = 1'b0;
    mn = (which == 1) ? 5 : 3;
    mk = (which == 1) ? 4 : 3;
    model_reset();
  endtask

  // One button press held for 'hold' cycles, checked against the model.
  task automatic press(input logic [4:0] b, input int hold);
    int n, ill_seen, chk_seen, chk_min, chk_max, exp_ill;
    bit settled;
    exp_ill = 0; chk_min = 0; chk_max = 0;
    if (mwin != 0) begin
      if (b[4]) model_reset();
    end else if (b[4]) begin
      if (mb[mr][mc] != 0) exp_ill = 1;
      else begin
        mb[mr][mc] = mturn + 1;
        mmoves++;
        if (has_line(mturn + 1)) begin
          mwin = mturn + 1; chk_min = 1; chk_max = 4;
        end else begin
          chk_min = 4; chk_max = 4;
          if (mmoves == mn * mn) mwin = 3;
          else mturn = 1 - mturn;
        end
      end
    end else if (b[3]) mc = (mc + 1) % mn;
    else if (b[2]) mc = (mc + mn - 1) % mn;
    else if (b[1]) mr = (mr + mn - 1) % mn;
    else if (b[0]) mr = (mr + 1) % mn;

    n = 0;
    @(negedge clk);
    while (!(st_wp || st_win || st_draw) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("[TB] FAIL ready_timeout sel=%0d got=not_ready want=ready", sel);
    end
    set_btn(b);
    ill_seen = 0; chk_seen = 0; settled = 1'b0;
    for (int k = 0; k < 40 && !settled; k++) begin
      @(negedge clk);
      if (o_ill) ill_seen++;
      if (st_chk) chk_seen++;
      if (k + 1 >= hold) begin
        set_btn('0);
        if (st_wp || st_win || st_draw) settled = 1'b1;
      end
    end
    set_btn('0);
    total++;
    if (!settled) begin
      bad++; $display("[TB] FAIL settle_timeout sel=%0d got=busy want=idle", sel);
    end
    total++;
    if (ill_seen != exp_ill) begin
      bad++; $display("[TB] FAIL illegal_pulse sel=%0d btn=%b got=%0d want=%0d", sel, b, ill_seen, exp_ill);
    end
    total++;
    if (chk_seen < chk_min || chk_seen > chk_max) begin
      bad++; $display("[TB] FAIL check_cycles sel=%0d got=%0d want=%0d..%0d", sel, chk_seen, chk_min, chk_max);
    end
    total++;
    if (int'(o_turn) != mturn) begin
      bad++; $display("[TB] FAIL turn sel=%0d got=%0d want=%0d", sel, o_turn, mturn);
    end
    total++;
    if (int'(o_winner) != mwin) begin
      bad++; $display("[TB] FAIL winner sel=%0d got=%0d want=%0d", sel, o_winner, mwin);
    end
    total++;
    if (o_moves != mmoves) begin
      bad++; $display("[TB] FAIL moves sel=%0d got=%0d want=%0d", sel, o_moves, mmoves);
    end
  endtask

  // Rendered screen versus model: blanking, every cell corner (owner colour),
  // every cell centre (green on the cursor) and one gap pixel.
  task automatic check_screen();
    int x0, y0;
    logic [11:0] want;
    bright = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (o_rgb !== 12'h000) begin
      bad++; $display("[TB] FAIL blank_black got=%h want=000", o_rgb);
    end
    bright = 1'b1;
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++) begin
        x0 = 308 + c * 105;
        y0 = 120 + r * 105;
        hCount = 10'(x0 + 3); vCount = 10'(y0 + 3);
        @(negedge clk);
        want = owner_colour(r, c);
        total++;
        if (o_rgb !== want) begin
          bad++; $display("[TB] FAIL cell_corner r=%0d c=%0d got=%h want=%h", r, c, o_rgb, want);
        end
        hCount = 10'(x0 + 50); vCount = 10'(y0 + 50);
        @(negedge clk);
        want = (r == mr && c == mc) ? C_GREEN : owner_colour(r, c);
        total++;
        if (o_rgb !== want) begin
          bad++; $display("[TB] FAIL cell_centre r=%0d c=%0d got=%h want=%h", r, c, o_rgb, want);
        end
      end
    hCount = 10'(308 + 102); vCount = 10'(120 + 20);
    @(negedge clk);
    total++;
    if (o_rgb !== C_WHITE) begin
      bad++; $display("[TB] FAIL gap_white got=%h want=%h", o_rgb, C_WHITE);
    end
  endtask

  task automatic goto(input int r, input int c);
    for (int i = 0; i < 2 * mn && mc != c; i++) press(B_RIGHT, 1);
    for (int i = 0; i < 2 * mn && mr != r; i++) press(B_DOWN, 1);
  endtask

  task automatic place_at(input int r, input int c);
    goto(r, c);
    press(B_PLACE, 1);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (st_init !== 1'b1) begin bad++; $display("[TB] FAIL reset_state got=%b want=1", st_init); end
    total++;
    if (o_turn !== 1'b0) begin bad++; $display("[TB] FAIL reset_turn got=%b want=0", o_turn); end
    total++;
    if (o_winner !== 2'b00) begin bad++; $display("[TB] FAIL reset_winner got=%b want=00", o_winner); end
    total++;
    if (o_moves != 0) begin bad++; $display("[TB] FAIL reset_moves got=%0d want=0", o_moves); end
    total++;
    if (o_ill !== 1'b0) begin bad++; $display("[TB] FAIL reset_illegal got=%b want=0", o_ill); end
    total++;
    if (o_rgb !== 12'h000) begin bad++; $display("[TB] FAIL reset_rgb got=%h want=000", o_rgb); end
    @(negedge clk);
    rst = 1'b0;
    mn = 3; mk = 3;
    model_reset();
    check_screen();
  endtask

  task automatic test_cursor_wrap();
    hard_reset(0);
    for (int i = 0; i < 3; i++) begin
      press(B_RIGHT, 1 + i);
      check_screen();
    end
    press(B_UP, 1);
    press(B_UP, 2);
    total++;
    if (mr != 2) begin bad++; $display("[TB] FAIL wrap_row_model got=%0d want=2", mr); end
    check_screen();
  endtask

  task automatic test_win_row();
    int rs[5] = '{0, 1, 0, 1, 0};
    int cs[5] = '{0, 0, 1, 1, 2};
    hard_reset(0);
    for (int i = 0; i < 5; i++) place_at(rs[i], cs[i]);
    total++;
    if (o_winner !== 2'b01) begin bad++; $display("[TB] FAIL row_win got=%b want=01", o_winner); end
    press(B_RIGHT, 1);
    press(B_DOWN, 2);
    check_screen();
    press(B_PLACE, 1);
    total++;
    if (o_moves != 0) begin bad++; $display("[TB] FAIL new_game_moves got=%0d want=0", o_moves); end
  endtask

  task automatic test_illegal();
    hard_reset(0);
    place_at(1, 1);
    press(B_PLACE, 1);
    total++;
    if (o_turn !== 1'b1 || o_moves != 1) begin
      bad++; $display("[TB] FAIL illegal_keeps got=turn%0d/moves%0d want=turn1/moves1", o_turn, o_moves);
    end
    check_screen();
  endtask

  task automatic test_draw();
    int rs[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int cs[9] = '{0, 1, 2, 1, 0, 2, 1, 0, 2};
    hard_reset(0);
    for (int i = 0; i < 9; i++) place_at(rs[i], cs[i]);
    total++;
    if (o_winner !== 2'b11 || o_moves != 9) begin
      bad++; $display("[TB] FAIL draw got=%b/%0d want=11/9", o_winner, o_moves);
    end
    check_screen();
  endtask

  task automatic test_anti_diag();
    int rs[8] = '{0, 0, 0, 1, 4, 2, 4, 3};
    int cs[8] = '{0, 4, 1, 3, 4, 2, 3, 1};
    int es[6] = '{4, 0, 3, 1, 4, 2};
    int ec[6] = '{4, 2, 4, 1, 2, 0};
    hard_reset(1);
    for (int i = 0; i < 8; i++) place_at(rs[i], cs[i]);
    total++;
    if (o_winner !== 2'b10) begin bad++; $display("[TB] FAIL anti_diag_win got=%b want=10", o_winner); end
    check_screen();
    hard_reset(1);
    for (int i = 0; i < 6; i++) place_at(es[i], ec[i]);
    total++;
    if (o_winner !== 2'b00 || o_moves != 6) begin
      bad++; $display("[TB] FAIL edge_run3 got=%b/%0d want=00/6", o_winner, o_moves);
    end
  endtask

  task automatic test_reset_mid_check();
    int n;
    hard_reset(0);
    press(B_RIGHT, 1);
    bright = 1'b1; hCount = 10'(308 + 3); vCount = 10'(120 + 3);
    n = 0;
    while (!st_wp && n < 20) begin @(negedge clk); n++; end
    set_btn(B_PLACE);
    @(negedge clk);
    total++;
    if (st_chk !== 1'b1 || o_moves != 1) begin
      bad++; $display("[TB] FAIL enter_check got=%b/%0d want=1/1", st_chk, o_moves);
    end
    rst = 1'b1;
    set_btn(B_RIGHT);
    #1;
    total++;
    if (st_init !== 1'b1 || o_moves != 0 || o_turn !== 1'b0 || o_winner !== 2'b00 ||
        o_ill !== 1'b0 || o_rgb !== 12'h000) begin
      bad++; $display("[TB] FAIL async_reset got=init%b moves%0d turn%b win%b ill%b rgb%h want=init1 zeros",
                      st_init, o_moves, o_turn, o_winner, o_ill, o_rgb);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (st_wr !== 1'b1) begin bad++; $display("[TB] FAIL held_after_reset got=%b want=1", st_wr); end
    set_btn('0);
    model_reset();
    repeat (2) @(negedge clk);
    check_screen();
  endtask

  task automatic test_random(input int which);
    logic [4:0] mask;
    int hold;
    hard_reset(which);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 4) mask = B_PLACE;
      else mask = 5'($urandom_range(1, 31));
      hold = mask[4] ? 1 : int'($urandom_range(1, 3));
      press(mask, hold);
      if (i % 10 == 9) check_screen();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sel = 0; rst = 1'b0; b3 = '0; b5 = '0;
    bright = 1'b0; hCount = '0; vCount = '0;
    mn = 3; mk = 3;
    model_reset();
    #2 rst = 1'b1;
    test_reset();
    test_cursor_wrap();
    test_win_row();
    test_illegal();
    test_draw();
    test_anti_diag();
    test_reset_mid_check();
    test_random(0);
    test_random(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
